// File: rtl/rr_dec_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter and its grant decoder.
package rr_dec_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;
endpackage

// File: rtl/rr_dec_arbiter_dec.sv
// 3-to-8 one-hot decoder with enable; combinational, zero latency, no flow control.
module dec3to8_en
  import rr_dec_pkg::*;
(
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// 8-way round-robin arbiter with hold limit; grant 1 cycle after request, at least 2 idle cycles between owners.
// No preemption: other requesters wait until the owner releases or hits MAX_HOLD.
module rr_dec_arbiter
  import rr_dec_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       hold_q, hold_d;
  logic             timeout_q, timeout_d;

  // First requester at or after the pointer, wrapping modulo 8.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] k;
    logic             hit;
    rr_pick = p;
    hit     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = p + IDX_W'(i);
      if (!hit && r[k]) begin
        rr_pick = k;
        hit     = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          idx_d   = rr_pick(req_i, ptr_q);
          hold_d  = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_i[idx_q]) begin
          state_d = GAP;
          ptr_d   = idx_q + 3'd1;
        end else if (hold_q == HOLD_LIMIT) begin
          state_d   = GAP;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_o      = (state_q == GRANT);
  assign grant_idx_o = idx_q;
  assign timeout_o   = timeout_q;

  dec3to8_en u_dec (
    .en_i     (busy_o),
    .idx_i    (idx_q),
    .onehot_o (grant_o)
  );

endmodule
